// File: rtl/fifo_ms_pkg.sv
// Shared definitions for the multi-stream tagged FIFO and its drain side.
// Holds the drain FSM state encoding and the tag-field geometry helpers
// used by both the FIFO write side and the drain, so that the tag position
// is defined in exactly one place.
package fifo_ms_pkg;

    // Drain FSM state encoding.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Width of the flux tag; a single flux still gets one tag bit.
    function automatic int unsigned tag_width(input int unsigned flux);
        return (flux <= 1) ? 1 : $clog2(flux);
    endfunction

    // Most significant bit of the tag field inside a FIFO word.
    function automatic int unsigned tag_msb(input int unsigned width);
        return width - 1;
    endfunction

    // Least significant bit of the tag field inside a FIFO word.
    function automatic int unsigned tag_lsb(input int unsigned width, input int unsigned flux);
        return width - tag_width(flux);
    endfunction

    // Payload width left once the tag is stripped.
    function automatic int unsigned payload_width(input int unsigned width, input int unsigned flux);
        return width - tag_width(flux);
    endfunction

    // Width of the grant counter.
    localparam int unsigned GRANT_CNT_W = 16;

endpackage

// File: rtl/fifo_ms_drain_rr_pick.sv
// Combinational round-robin picker for the drain arbiter.
// Ports:
//   req     - per-flux request (flux non-empty)
//   last    - flux granted most recently; search starts just above it
//   prio_en - when set, flux FLUX-1 wins whenever it requests
//   winner  - selected flux index (valid only when any is set)
//   any     - at least one request is active
module rr_pick
    import fifo_ms_pkg::*;
#(
    parameter  int unsigned FLUX      = 2,
    localparam int unsigned TAG_WIDTH = tag_width(FLUX)
) (
    input  logic [FLUX-1:0]      req,
    input  logic [TAG_WIDTH-1:0] last,
    input  logic                 prio_en,
    output logic [TAG_WIDTH-1:0] winner,
    output logic                 any
);

    // Priority override first, then first requester at (last+k) mod FLUX.
    always_comb begin
        int unsigned idx;
        logic        found;

        winner = '0;
        any    = |req;
        found  = 1'b0;
        idx    = 0;

        if (prio_en && req[FLUX-1]) begin
            winner = TAG_WIDTH'(FLUX - 1);
            found  = 1'b1;
        end

        for (int unsigned k = 1; k <= FLUX; k++) begin
            idx = (32'(last) + k) % FLUX;
            for (int unsigned i = 0; i < FLUX; i++) begin
                if (!found && req[i] && (idx == i)) begin
                    winner = TAG_WIDTH'(i);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_ms_drain.sv
// Drain side of the multi-stream tagged FIFO.
// Grants one flux at a time (round-robin, optional FLUX-1 urgency), pulses a
// one-hot rd to pull up to BURST words from the granted flux, and registers
// each word into a valid/ready output stage with the tag replaced by the flux id.
// Ports:
//   ck, rst           - clock, asynchronous active-low reset
//   empty             - per-flux empty flags from the FIFO
//   dataout           - first-word-fall-through head of the flux selected by rd
//   rd                - one-hot read strobe (combinational, zero when idle)
//   out_valid/ready   - output handshake
//   out_data          - payload with tag stripped
//   out_flux          - flux the word came from
//   out_last          - word closes a full BURST-length grant
//   grant_cnt         - grants issued since reset, wrapping
module fifo_ms_drain
    import fifo_ms_pkg::*;
#(
    parameter  int unsigned WIDTH     = 8,
    parameter  int unsigned FLUX      = 2,
    parameter  int unsigned BURST     = 4,
    parameter  int unsigned PRIO      = 1,
    localparam int unsigned TAG_WIDTH = tag_width(FLUX),
    localparam int unsigned PAY_WIDTH = payload_width(WIDTH, FLUX)
) (
    input  logic                   ck,
    input  logic                   rst,
    input  logic [FLUX-1:0]        empty,
    input  logic [WIDTH-1:0]       dataout,
    output logic [FLUX-1:0]        rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PAY_WIDTH-1:0]   out_data,
    output logic [TAG_WIDTH-1:0]   out_flux,
    output logic                   out_last,
    output logic [GRANT_CNT_W-1:0] grant_cnt
);

    localparam int unsigned BCNT_W  = $clog2(BURST + 1);
    localparam int unsigned TAG_LSB = tag_lsb(WIDTH, FLUX);
    localparam int unsigned TAG_MSB = tag_msb(WIDTH);

    state_e                 state_q, state_d;
    logic [TAG_WIDTH-1:0]   gnt_q, gnt_d;
    logic [TAG_WIDTH-1:0]   last_gnt_q, last_gnt_d;
    logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
    logic                   out_valid_d;
    logic [PAY_WIDTH-1:0]   out_data_d;
    logic [TAG_WIDTH-1:0]   out_flux_d;
    logic                   out_last_d;
    logic [GRANT_CNT_W-1:0] grant_cnt_d;

    logic                   can_load_c;
    logic                   gnt_empty_c;
    logic                   rd_en_c;
    logic                   burst_end_c;
    logic [TAG_WIDTH-1:0]   pick_winner;
    logic                   pick_any;
    logic                   tag_unused;

    // Tag bits are not cross-checked against the grant.
    assign tag_unused = ^dataout[TAG_MSB:TAG_LSB];

    // Arbitration among non-empty fluxes.
    rr_pick #(
        .FLUX (FLUX)
    ) u_pick (
        .req     (~empty),
        .last    (last_gnt_q),
        .prio_en (PRIO != 0),
        .winner  (pick_winner),
        .any     (pick_any)
    );

    // Read strobe, next-state and output-stage next values.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        bcnt_d      = bcnt_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_flux_d  = out_flux;
        out_last_d  = out_last;
        grant_cnt_d = grant_cnt;
        gnt_empty_c = 1'b0;
        rd          = '0;

        for (int unsigned i = 0; i < FLUX; i++) begin
            if (gnt_q == TAG_WIDTH'(i)) begin
                gnt_empty_c = empty[i];
            end
        end

        // A read may happen only when the output slot is free or draining now.
        can_load_c  = !out_valid || out_ready;
        rd_en_c     = (state_q == DRAIN) && can_load_c && !gnt_empty_c;
        burst_end_c = (bcnt_q == BCNT_W'(BURST - 1));

        for (int unsigned i = 0; i < FLUX; i++) begin
            rd[i] = rd_en_c && (gnt_q == TAG_WIDTH'(i));
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = DRAIN;
                    gnt_d       = pick_winner;
                    last_gnt_d  = pick_winner;
                    bcnt_d      = '0;
                    grant_cnt_d = grant_cnt + GRANT_CNT_W'(1);
                end
            end
            DRAIN: begin
                if (rd_en_c) begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                    if (burst_end_c) begin
                        state_d = IDLE;
                    end
                end else if (gnt_empty_c) begin
                    // Flux ran dry before the burst completed.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Load beats clear, so a simultaneous handshake keeps out_valid high.
        if (rd_en_c) begin
            out_valid_d = 1'b1;
            out_data_d  = dataout[PAY_WIDTH-1:0];
            out_flux_d  = gnt_q;
            out_last_d  = burst_end_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // All state and registered outputs.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= TAG_WIDTH'(FLUX - 1);
            bcnt_q     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_flux   <= '0;
            out_last   <= 1'b0;
            grant_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            bcnt_q     <= bcnt_d;
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            out_flux   <= out_flux_d;
            out_last   <= out_last_d;
            grant_cnt  <= grant_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_ms_drain.sv
// Bench for fifo_ms_drain: two instances (PRIO=0 and PRIO=1) each fed by a
// small FWFT multi-stream FIFO model; outputs are compared against a
// transaction-level model of the grant/burst rules.
module tb_fifo_ms_drain;

    localparam int WIDTH = 8;
    localparam int FLUX  = 2;
    localparam int BURST = 4;
    localparam int TW    = 1;
    localparam int PW    = WIDTH - TW;
    localparam int NU    = 2;
    localparam int REC_W = TW + PW + 1;

    logic ck = 1'b0;
    logic rst;

    logic [FLUX-1:0]  empty     [NU];
    logic [FLUX-1:0]  rd        [NU];
    logic [WIDTH-1:0] dataout   [NU];
    logic             out_valid [NU];
    logic             out_ready [NU];
    logic [PW-1:0]    out_data  [NU];
    logic [TW-1:0]    out_flux  [NU];
    logic             out_last  [NU];
    logic [15:0]      grant_cnt [NU];

    always #5 ck = ~ck;

    fifo_ms_drain #(.WIDTH(WIDTH), .FLUX(FLUX), .BURST(BURST), .PRIO(0)) dut (
        .ck(ck), .rst(rst), .empty(empty[0]), .dataout(dataout[0]), .rd(rd[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_flux(out_flux[0]), .out_last(out_last[0]), .grant_cnt(grant_cnt[0])
    );

    fifo_ms_drain #(.WIDTH(WIDTH), .FLUX(FLUX), .BURST(BURST), .PRIO(1)) dut_p (
        .ck(ck), .rst(rst), .empty(empty[1]), .dataout(dataout[1]), .rd(rd[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_flux(out_flux[1]), .out_last(out_last[1]), .grant_cnt(grant_cnt[1])
    );

    // FIFO model: per instance, per flux circular store with FWFT head.
    logic [WIDTH-1:0] mem [NU][FLUX][256];
    logic [7:0]       rp  [NU][FLUX];
    logic [7:0]       wp  [NU][FLUX];
    logic             fifo_clr;

    always_comb begin
        for (int u = 0; u < NU; u++) begin
            dataout[u] = '0;
            for (int i = 0; i < FLUX; i++) begin
                empty[u][i] = (rp[u][i] == wp[u][i]);
                if (rd[u][i]) dataout[u] = mem[u][i][rp[u][i]];
            end
        end
    end

    always @(posedge ck) begin
        for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < FLUX; i++) begin
                if (fifo_clr) rp[u][i] <= 8'd0;
                else if (rd[u][i]) rp[u][i] <= rp[u][i] + 8'd1;
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0]    load_q [FLUX][$];
    logic [REC_W-1:0] exp_q  [NU][$];
    logic [REC_W-1:0] obs_q  [NU][$];
    int               model_last [NU];
    int               exp_gc     [NU];
    logic [FLUX-1:0]  rd_trace [$];
    logic             ov_trace [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input int u, input int f, input logic [PW-1:0] d);
        mem[u][f][wp[u][f]] = {TW'(f), d};
        wp[u][f] = wp[u][f] + 8'd1;
    endtask

    // Transaction model: grants pick a non-empty flux (priority, then
    // round-robin after the last grant) and take min(BURST, remaining) words;
    // only a full BURST marks its final word as last.
    task automatic model_build(input int u, input bit prio);
        int rem [FLUX];
        int pos [FLUX];
        int f, n, c;
        bit found;
        logic [REC_W-1:0] rec;
        for (int i = 0; i < FLUX; i++) begin
            rem[i] = load_q[i].size();
            pos[i] = 0;
        end
        for (int g = 0; g < 256; g++) begin
            found = 1'b0;
            f = 0;
            if (prio && rem[FLUX-1] > 0) begin
                f = FLUX - 1;
                found = 1'b1;
            end
            for (int k = 1; k <= FLUX; k++) begin
                c = (model_last[u] + k) % FLUX;
                if (!found && rem[c] > 0) begin
                    f = c;
                    found = 1'b1;
                end
            end
            if (!found) break;
            n = (rem[f] < BURST) ? rem[f] : BURST;
            for (int j = 0; j < n; j++) begin
                rec = {TW'(f), load_q[f][pos[f] + j], 1'((n == BURST) && (j == n - 1))};
                exp_q[u].push_back(rec);
            end
            pos[f] += n;
            rem[f] -= n;
            model_last[u] = f;
            exp_gc[u]++;
        end
    endtask

    function automatic logic ready_val(input int mode, input int cyc);
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        if (mode == 2) return !(cyc >= 3 && cyc <= 5);
        return 1'b1;
    endfunction

    task automatic run_scenario(input string name, input int mode);
        bit            stall_prev [NU];
        logic [PW-1:0] hold_d [NU];
        logic [TW-1:0] hold_f [NU];
        int            tail;
        bit            done;

        for (int u = 0; u < NU; u++) begin
            exp_q[u].delete();
            obs_q[u].delete();
            model_build(u, u == 1);
            stall_prev[u] = 1'b0;
            hold_d[u] = '0;
            hold_f[u] = '0;
            for (int f = 0; f < FLUX; f++)
                for (int j = 0; j < load_q[f].size(); j++) push_word(u, f, load_q[f][j]);
        end
        rd_trace.delete();
        ov_trace.delete();
        tail = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int u = 0; u < NU; u++) out_ready[u] = ready_val(mode, cyc);
            #1;
            for (int u = 0; u < NU; u++) begin
                if (stall_prev[u]) begin
                    chk($sformatf("%s_hold_valid_u%0d", name, u), 32'(out_valid[u]), 32'd1);
                    chk($sformatf("%s_hold_data_u%0d", name, u),
                        32'({out_flux[u], out_data[u]}), 32'({hold_f[u], hold_d[u]}));
                end
                for (int i = 0; i < FLUX; i++)
                    if (rd[u][i]) chk($sformatf("%s_rd_nonempty_u%0d", name, u), 32'(empty[u][i]), 32'd0);
                if (rd[u] != '0)
                    chk($sformatf("%s_rd_onehot_u%0d", name, u), 32'($countones(rd[u])), 32'd1);
                if (out_valid[u] && !out_ready[u]) begin
                    chk($sformatf("%s_bp_rd_u%0d", name, u), 32'(rd[u]), 32'd0);
                    stall_prev[u] = 1'b1;
                    hold_d[u] = out_data[u];
                    hold_f[u] = out_flux[u];
                end else begin
                    stall_prev[u] = 1'b0;
                end
                if (out_valid[u] && out_ready[u])
                    obs_q[u].push_back({out_flux[u], out_data[u], out_last[u]});
            end
            rd_trace.push_back(rd[0]);
            ov_trace.push_back(out_valid[0]);
            @(negedge ck);
            done = (obs_q[0].size() >= exp_q[0].size()) && (obs_q[1].size() >= exp_q[1].size());
            if (done) tail++;
            if (tail == 4) break;
        end

        for (int u = 0; u < NU; u++) begin
            chk($sformatf("%s_count_u%0d", name, u), 32'(obs_q[u].size()), 32'(exp_q[u].size()));
            for (int k = 0; k < exp_q[u].size(); k++)
                if (k < obs_q[u].size())
                    chk($sformatf("%s_word_u%0d_%0d", name, u, k), 32'(obs_q[u][k]), 32'(exp_q[u][k]));
            chk($sformatf("%s_grant_cnt_u%0d", name, u), 32'(grant_cnt[u]), 32'(exp_gc[u] & 16'hFFFF));
            chk($sformatf("%s_drained_u%0d", name, u), 32'(empty[u]), 32'({FLUX{1'b1}}));
        end
        for (int f = 0; f < FLUX; f++) load_q[f].delete();
    endtask

    logic [FLUX-1:0] exp_rd [9]  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    logic            exp_ov [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b0;
        fifo_clr = 1'b1;
        for (int u = 0; u < NU; u++) begin
            out_ready[u] = 1'b0;
            model_last[u] = FLUX - 1;
            exp_gc[u] = 0;
            for (int i = 0; i < FLUX; i++) wp[u][i] = 8'd0;
        end
        repeat (3) @(negedge ck);
        fifo_clr = 1'b0;
        #1;
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("rst_rd_u%0d", u), 32'(rd[u]), 32'd0);
            chk($sformatf("rst_out_valid_u%0d", u), 32'(out_valid[u]), 32'd0);
            chk($sformatf("rst_out_data_u%0d", u), 32'(out_data[u]), 32'd0);
            chk($sformatf("rst_out_flux_u%0d", u), 32'(out_flux[u]), 32'd0);
            chk($sformatf("rst_out_last_u%0d", u), 32'(out_last[u]), 32'd0);
            chk($sformatf("rst_grant_cnt_u%0d", u), 32'(grant_cnt[u]), 32'd0);
        end
        @(negedge ck);
        rst = 1'b1;

        // Single flux: 0x01..0x06 on flux 0, full-rate output.
        for (int j = 0; j < 6; j++) load_q[0].push_back(PW'(j + 1));
        run_scenario("single", 0);
        for (int k = 0; k < 9; k++)
            if (k < rd_trace.size()) chk($sformatf("single_rd_trace_%0d", k), 32'(rd_trace[k]), 32'(exp_rd[k]));
        for (int k = 0; k < 10; k++)
            if (k < ov_trace.size()) chk($sformatf("single_valid_trace_%0d", k), 32'(ov_trace[k]), 32'(exp_ov[k]));

        // Both fluxes full: alternation (PRIO=0) vs urgency (PRIO=1).
        for (int f = 0; f < FLUX; f++)
            for (int j = 0; j < 8; j++) load_q[f].push_back(PW'($urandom));
        run_scenario("rr", 0);

        // Three-cycle stall during a burst.
        for (int f = 0; f < FLUX; f++)
            for (int j = 0; j < 6; j++) load_q[f].push_back(PW'($urandom));
        run_scenario("backpressure", 2);

        // Early empty on flux 1, then both fluxes to see where the search resumes.
        for (int j = 0; j < 2; j++) load_q[1].push_back(PW'($urandom));
        run_scenario("early_empty", 0);
        for (int f = 0; f < FLUX; f++)
            for (int j = 0; j < 3; j++) load_q[f].push_back(PW'($urandom));
        run_scenario("after_early", 0);

        // Random fills with random backpressure.
        for (int r = 0; r < 6; r++) begin
            for (int f = 0; f < FLUX; f++) begin
                int n;
                n = $urandom_range(0, 10);
                for (int j = 0; j < n; j++) load_q[f].push_back(PW'($urandom));
            end
            run_scenario($sformatf("rand%0d", r), 1);
        end

        // Reset mid-burst with a stalled output word.
        for (int u = 0; u < NU; u++) begin
            out_ready[u] = 1'b0;
            for (int j = 0; j < 6; j++) push_word(u, 0, PW'($urandom));
        end
        repeat (3) @(negedge ck);
        #2;
        for (int u = 0; u < NU; u++)
            chk($sformatf("midrst_pre_valid_u%0d", u), 32'(out_valid[u]), 32'd1);
        rst = 1'b0;
        #1;
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("midrst_rd_u%0d", u), 32'(rd[u]), 32'd0);
            chk($sformatf("midrst_out_valid_u%0d", u), 32'(out_valid[u]), 32'd0);
            chk($sformatf("midrst_grant_cnt_u%0d", u), 32'(grant_cnt[u]), 32'd0);
            for (int i = 0; i < FLUX; i++) wp[u][i] = rp[u][i];
            model_last[u] = FLUX - 1;
            exp_gc[u] = 0;
        end
        @(negedge ck);
        rst = 1'b1;

        for (int f = 0; f < FLUX; f++)
            for (int j = 0; j < 5; j++) load_q[f].push_back(PW'($urandom));
        run_scenario("post_reset", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
